// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One partial product per clock, start/busy/done handshake, optional
// two's-complement mode chosen per operation.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - synchronous active-low reset
//   start  - operation request, sampled only in IDLE
//   sgn    - 1: operands are signed, 0: unsigned (sampled with start)
//   a      - multiplier (sampled with start)
//   b      - multiplicand (sampled with start)
//   busy   - high whenever an operation is in flight (CALC or DONE)
//   done   - one-cycle pulse, p valid and new
//   p      - registered product, holds until the next done
module seq_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int unsigned P_W   = 2 * WIDTH;
  localparam int unsigned S_W   = WIDTH + 1;
  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;      // upper half of the running product
  logic [WIDTH-1:0]   mpl_q, mpl_d;    // multiplier, shifts right; low half fills in behind it
  logic [WIDTH-1:0]   mcd_q, mcd_d;    // multiplicand magnitude
  logic               neg_q, neg_d;    // result sign for signed operations
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [P_W-1:0]     p_q, p_d;

  logic [S_W-1:0]     sum;
  logic [P_W-1:0]     prod;
  logic [WIDTH-1:0]   mag_a, mag_b;

  // Operand magnitudes; the most negative value maps onto its unsigned
  // WIDTH-bit magnitude, so no extra bit is needed.
  always_comb begin
    mag_a = (sgn && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
    mag_b = (sgn && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;
  end

  // One shift-add step: the carry of the add lands in the top bit after
  // the right shift, and the sum LSB moves into the low half.
  always_comb begin
    sum  = {1'b0, hi_q} + (mpl_q[0] ? {1'b0, mcd_q} : {S_W{1'b0}});
    prod = {sum, mpl_q[WIDTH-1:1]};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    mpl_d   = mpl_q;
    mcd_d   = mcd_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    p_d     = p_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          mpl_d   = mag_a;
          mcd_d   = mag_b;
          neg_d   = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          hi_d    = {WIDTH{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
        end
      end
      CALC: begin
        hi_d  = sum[WIDTH:1];
        mpl_d = {sum[0], mpl_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
          done_d  = 1'b1;
          p_d     = neg_q ? ({P_W{1'b0}} - prod) : prod;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hi_q    <= '0;
      mpl_q   <= '0;
      mcd_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      mpl_q   <= mpl_d;
      mcd_q   <= mcd_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      p_q     <= p_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier at WIDTH=4 and WIDTH=8 against an arithmetic
// reference product.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start4, sgn4, busy4, done4;
  logic [3:0] a4, b4;
  logic [7:0] p4;
  logic       start8, sgn8, busy8, done8;
  logic [7:0] a8, b8;
  logic [15:0] p8;

  int n_vec = 0;
  int n_err = 0;
  int n_done4 = 0;
  int n_start4 = 0;

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sgn(sgn4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .p(p4)
  );

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sgn(sgn8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8)
  );

  always @(posedge clk) if (done4) n_done4++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference product: interpret operands per mode, multiply, keep 2*w bits.
  function automatic longint ref_prod(input int w, input bit s, input longint x, input longint y);
    longint xv, yv;
    xv = x;
    yv = y;
    if (s) begin
      if (xv >= (64'sd1 <<< (w - 1))) xv = xv - (64'sd1 <<< w);
      if (yv >= (64'sd1 <<< (w - 1))) yv = yv - (64'sd1 <<< w);
    end
    return (xv * yv) & ((64'sd1 <<< (2 * w)) - 1);
  endfunction

  // Issue one WIDTH=4 operation from an IDLE cycle; operands are scrambled
  // while it runs. Returns one cycle after done, in IDLE.
  task automatic op4(input bit s, input logic [3:0] x, input logic [3:0] y, input string tag);
    int cyc;
    logic [7:0] exp;
    exp = 8'(ref_prod(4, s, longint'(x), longint'(y)));
    sgn4 = s; a4 = x; b4 = y; start4 = 1'b1;
    n_start4++;
    @(posedge clk); #1;
    start4 = 1'b0;
    cyc = 0;
    while (!done4 && cyc < 20) begin
      a4 = 4'($urandom); b4 = 4'($urandom); sgn4 = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) check({tag, " busy"}, busy4, 1'b1);
    end
    check({tag, " latency"}, cyc, 4);
    check({tag, " p"}, p4, exp);
    @(posedge clk); #1;
    check({tag, " done width"}, done4, 1'b0);
    check({tag, " busy after"}, busy4, 1'b0);
  endtask

  task automatic op8(input bit s, input logic [7:0] x, input logic [7:0] y, input string tag);
    int cyc;
    logic [15:0] exp;
    exp = 16'(ref_prod(8, s, longint'(x), longint'(y)));
    sgn8 = s; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 0;
    while (!done8 && cyc < 30) begin
      a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, cyc, 8);
    check({tag, " p"}, p8, exp);
    @(posedge clk); #1;
    check({tag, " done width"}, done8, 1'b0);
    check({tag, " busy after"}, busy8, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int extra;
    rst_n = 1'b0;
    start4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy4", busy4, 1'b0);
    check("rst done4", done4, 1'b0);
    check("rst p4", p4, 8'h00);
    check("rst p8", p8, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op4(1'b0, 4'd15, 4'd15, "u15x15");
    check("u15x15 const", p4, 8'hE1);
    op4(1'b1, 4'b1000, 4'b1000, "s-8x-8");
    check("s-8x-8 const", p4, 8'h40);
    op4(1'b1, 4'b1000, 4'd7, "s-8x7");
    check("s-8x7 const", p4, 8'hC8);
    op4(1'b1, 4'b1111, 4'd1, "s-1x1");
    check("s-1x1 const", p4, 8'hFF);

    // Exhaustive sweep, back-to-back issue on the first IDLE cycle.
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++)
          op4(1'(m), 4'(i), 4'(j), m ? "sweep s" : "sweep u");

    // start during CALC is ignored.
    sgn4 = 1'b0; a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
    n_start4++;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a4 = 4'd9; b4 = 4'd9; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    check("ignore done", done4, 1'b1);
    check("ignore p", p4, 8'h0F);
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done4) extra++;
    end
    check("ignore extra done", extra, 0);

    // Reset mid-operation aborts without done.
    sgn4 = 1'b0; a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort busy", busy4, 1'b0);
    check("abort p", p4, 8'h00);
    check("abort done", done4, 1'b0);
    extra = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done4) extra++;
    end
    check("abort no done", extra, 0);
    op4(1'b0, 4'd2, 4'd3, "after abort");
    check("after abort const", p4, 8'h06);

    // Randomised WIDTH=4 operations.
    for (int k = 0; k < 40; k++)
      op4(1'($urandom), 4'($urandom), 4'($urandom), "rand4");

    check("done count", n_done4, n_start4);

    // WIDTH=8.
    op8(1'b0, 8'd255, 8'd255, "u255x255");
    check("u255x255 const", p8, 16'hFE01);
    op8(1'b1, 8'h80, 8'h80, "s80x80");
    check("s80x80 const", p8, 16'h4000);
    for (int k = 0; k < 30; k++)
      op8(1'($urandom), 8'($urandom), 8'($urandom), "rand8");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised, iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, one partial product per clock.
- Start/busy/done handshake.
- Optional signed (two's-complement) mode selected per operation.
- Replaces the fixed 2x2 combinational array wherever operand width makes an array too large; serves the arithmetic datapath.

Parameters:
WIDTH, 4, operand width in bits (legal range 2..32); product width is 2*WIDTH.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only while in IDLE
sgn  input  1  1 = operands two's-complement signed, 0 = unsigned; sampled with start
a  input  WIDTH  multiplier; sampled with start
b  input  WIDTH  multiplicand; sampled with start
busy  output  1  high whenever state != IDLE
done  output  1  single-cycle pulse, p valid and new
p  output  2*WIDTH  product, registered; holds until next done

Behaviour:
- Reset: one clock; reset is synchronous and active-low.
  - rst_n=0 at a rising edge gives state=IDLE, busy=0, done=0, p=0, internal registers/counter cleared.
  - Reset mid-operation aborts it; no done is produced for the aborted operation.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at edge E0 captures the operands and goes to CALC.
  - If sgn=1, magnitudes |a|, |b| are captured (WIDTH-bit unsigned; -2^(WIDTH-1) maps to magnitude 2^(WIDTH-1), no overflow), plus neg = a[MSB] ^ b[MSB].
  - If sgn=0, operands are captured as-is and neg=0.
  - Accumulator is cleared and the step counter set to 0.
- CALC, one step per edge, WIDTH steps (edges E1..E_WIDTH):
  - If the current LSB of the multiplier register is 1, add multiplicand into the upper WIDTH+1 bits of the accumulator.
  - Then shift {carry, acc, mplier} right by 1 and increment the counter.
  - On the step where counter == WIDTH-1, transition to DONE.
  - p <= neg ? -(acc) : acc, truncated to 2*WIDTH (exact, no overflow possible). done <= 1.
- DONE:
  - Lasts exactly one cycle (the cycle after edge E_WIDTH).
  - At the next edge: done <= 0, state <= IDLE.
- Latency: start sampled at E0; done=1 and p valid during the cycle following E_WIDTH, i.e. WIDTH clocks after start. Issue-to-issue minimum is WIDTH+2 clocks.
- busy is 1 in CALC and DONE, and 0 in the cycle after E0 only if reset intervened.
- start asserted in CALC or DONE is ignored and has no effect on the in-flight operation (no queuing). Holding start high continuously restarts a new operation on the first IDLE cycle.
- a, b and sgn changing during CALC do not affect the result.
- p changes only at the done edge or on reset. Between operations it holds the last product.
- Zero operands follow the same latency (no early termination).

Test Plan:
- WIDTH=4, reset held 2 cycles, then release -> busy=0, done=0, p=8'h00. Pulse start with sgn=0, a=15, b=15 -> done pulses exactly 4 clocks after start edge for one cycle, p=8'hE1, busy low one clock after done.
- WIDTH=4, sgn=1, a=4'b1000 (-8), b=4'b1000 (-8) -> p=8'h40. Then a=-8, b=7 -> p=8'hC8 (-56). Then a=-1, b=1 -> p=8'hFF.
- WIDTH=4, exhaustive unsigned and signed sweep over all 256 (a,b) pairs with back-to-back start -> every p matches the reference product; one done per accepted start.
- WIDTH=4, start a=3, b=5; at cycle 2 change a=9, b=9 and pulse start again -> p=8'h0F, only one done, the second start is ignored.
- WIDTH=4, start a=7, b=7, assert rst_n=0 at cycle 2 for one edge -> busy=0, p=0, no done. A subsequent start a=2, b=3 gives p=8'h06 after 4 clocks.
- WIDTH=8, sgn=0, a=255, b=255 -> p=16'hFE01, done 8 clocks after start. sgn=1, a=8'h80, b=8'h80 -> p=16'h4000.
